// File: rtl/result_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_packer_pkg
//  Description : Shared constants for the result packer: packed word layout,
//                FIFO sizing defaults and burst FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package result_packer_pkg;

   // Packed output word layout: {last, 2'b00, data[12:0]}
   localparam int PK_W     = 16;
   localparam int LAST_BIT = 15;
   localparam int DATA_LSB = 0;
   localparam int DATA_W   = 13;

   // FIFO sizing defaults; depth covers 32 channels x 4 pixels
   localparam int DEPTH_DEF = 128;
   localparam int AW_DEF    = 7;
   localparam int DW_DEF    = DATA_W;

   // Burst tracking FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // Build one packed word; padding bits between data and last stay zero
   function automatic logic [PK_W-1:0] pack_word(input logic last,
                                                 input logic [DATA_W-1:0] data);
      logic [PK_W-1:0] w;
      w                           = '0;
      w[LAST_BIT]                 = last;
      w[DATA_LSB +: DATA_W]       = data;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/result_packer_sync_fifo_rf.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_rf
//  Description : Register-file FIFO with combinational read port. The caller
//                guarantees i_push is only raised when not full or when a pop
//                happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_rf #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int W     = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-1:0]  o_rdata,
   output logic          o_full,
   output logic          o_empty
);

   localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
   localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   // Storage array write; contents need no reset since count gates the read
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy tracking, pointers wrap at DEPTH
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
         end
         if (i_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Status flags and head-of-queue read; data forced to zero while empty
   always_comb begin
      o_full  = (r_count == c_CNT_FULL);
      o_empty = (r_count == '0);
      o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
   end

endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : result_packer
//  Description : Captures unflow-controlled core output bursts, tags the last
//                sample of each burst, buffers them and re-emits 16-bit words
//                on a valid/ready interface. Reports burst length and a sticky
//                overflow flag for samples dropped on a full buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_packer
   import result_packer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_out_valid,
   input  logic [DW-1:0]   i_out_data,
   output logic            o_pk_valid,
   output logic [PK_W-1:0] o_pk_data,
   input  logic            i_pk_ready,
   output logic [7:0]      o_burst_len,
   output logic            o_burst_done,
   output logic            o_overflow,
   input  logic            i_clr_ovf
);

   logic            r_s_valid;
   logic [DW-1:0]   r_s_data;
   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [7:0]      r_bcnt;
   logic [7:0]      w_bcnt_nxt;
   logic [7:0]      w_sample_cnt;
   logic [7:0]      r_burst_len;
   logic [7:0]      w_len_nxt;
   logic            r_burst_done;
   logic            w_done;
   logic            r_overflow;
   logic            w_last;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [PK_W-1:0] w_word;

   // One-cycle stage so the following core sample can decide "last"
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
      end else begin
         r_s_valid <= i_out_valid;
         r_s_data  <= i_out_data;
      end
   end

   // Last tagging, FIFO handshake and write admission
   always_comb begin
      w_last     = ~i_out_valid;
      w_word     = pack_word(w_last, r_s_data);
      o_pk_valid = ~w_empty;
      w_pop      = o_pk_valid & i_pk_ready;
      w_push     = r_s_valid & (~w_full | w_pop);
   end

   sync_fifo_rf #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (PK_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_wdata (w_word),
      .i_pop   (w_pop),
      .o_rdata (o_pk_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Burst FSM state register with its counter and reported results
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_bcnt       <= '0;
         r_burst_len  <= '0;
         r_burst_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bcnt       <= w_bcnt_nxt;
         r_burst_len  <= w_len_nxt;
         r_burst_done <= w_done;
      end
   end

   // Burst FSM next state; a first sample already tagged last stays in IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (r_s_valid && !w_last) w_state_nxt = ST_BURST;
         ST_BURST: if (r_s_valid &&  w_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst FSM outputs; dropped samples are still counted
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_sample_cnt = 8'd1;
      end else if (r_bcnt == 8'hFF) begin
         w_sample_cnt = 8'hFF;
      end else begin
         w_sample_cnt = r_bcnt + 8'd1;
      end
      w_bcnt_nxt = r_bcnt;
      w_len_nxt  = r_burst_len;
      w_done     = 1'b0;
      if (r_s_valid) begin
         w_bcnt_nxt = w_sample_cnt;
         if (w_last) begin
            w_len_nxt = w_sample_cnt;
            w_done    = 1'b1;
         end
      end
   end

   // Sticky overflow; a fresh drop outranks a same-cycle clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
      end else if (r_s_valid && !w_push) begin
         r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign o_burst_len  = r_burst_len;
   assign o_burst_done = r_burst_done;
   assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_packer
//  Description : Self-checking bench for result_packer. A queue-based model
//                tracks expected packed words, burst lengths and overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_packer;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_out_valid;
   logic [12:0] i_out_data;
   logic        o_pk_valid;
   logic [15:0] o_pk_data;
   logic        i_pk_ready;
   logic [7:0]  o_burst_len;
   logic        o_burst_done;
   logic        o_overflow;
   logic        i_clr_ovf;

   always #5 i_clk = ~i_clk;

   result_packer dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_out_valid  (i_out_valid),
      .i_out_data   (i_out_data),
      .o_pk_valid   (o_pk_valid),
      .o_pk_data    (o_pk_data),
      .i_pk_ready   (i_pk_ready),
      .o_burst_len  (o_burst_len),
      .o_burst_done (o_burst_done),
      .o_overflow   (o_overflow),
      .i_clr_ovf    (i_clr_ovf)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [15:0] q[$];
   bit          m_sv;
   logic [12:0] m_sd;
   int          m_run;
   logic [7:0]  m_len;
   bit          m_done;
   bit          m_ovf;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_sv   = 1'b0;
      m_sd   = '0;
      m_run  = 0;
      m_len  = '0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Called at a falling edge: apply inputs, check outputs, advance model one cycle
   task automatic step(input bit iv, input logic [12:0] id, input bit rdy, input bit clr);
      bit pop, wr, last;
      int n;
      i_out_valid = iv;
      i_out_data  = id;
      i_pk_ready  = rdy;
      i_clr_ovf   = clr;
      chk("pk_valid", {15'b0, o_pk_valid}, {15'b0, (q.size() != 0)});
      if (q.size() != 0) chk("pk_data", o_pk_data, q[0]);
      chk("burst_len", {8'b0, o_burst_len}, {8'b0, m_len});
      chk("burst_done", {15'b0, o_burst_done}, {15'b0, m_done});
      chk("overflow", {15'b0, o_overflow}, {15'b0, m_ovf});
      n    = q.size();
      pop  = (n != 0) && rdy;
      last = !iv;
      wr   = (n < 128) || pop;
      if (pop) void'(q.pop_front());
      m_done = 1'b0;
      if (m_sv) begin
         if (wr) q.push_back({last, 2'b00, m_sd});
         m_run++;
         if (last) begin
            m_len  = (m_run > 255) ? 8'd255 : 8'(m_run);
            m_done = 1'b1;
            m_run  = 0;
         end
      end
      if (m_sv && !wr) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      m_sv = iv;
      m_sd = id;
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // rmode: 0 = stalled, 1 = always ready, 2 = random ready
   function automatic bit pick_rdy(input int rmode);
      if (rmode == 0) return 1'b0;
      if (rmode == 1) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic burst(input int len, input int rmode, input bit rnd, input int base);
      for (int i = 0; i < len; i++) begin
         step(1'b1, rnd ? 13'($urandom) : 13'(base + i), pick_rdy(rmode), 1'b0);
      end
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) step(1'b0, '0, pick_rdy(rmode), 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 400 && (q.size() != 0 || m_sv || m_done); k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
      end
      step(1'b0, '0, 1'b1, 1'b0);
   endtask

   logic [12:0] conv [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      conv[0] = 13'h1FFF;
      conv[1] = 13'h0000;
      conv[2] = 13'h0ABC;
      conv[3] = 13'h0001;
      i_rst_n     = 1'b0;
      i_out_valid = 1'b0;
      i_out_data  = '0;
      i_pk_ready  = 1'b0;
      i_clr_ovf   = 1'b0;
      model_clear();
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;

      // Reset state plus display burst 0..127 with a ready consumer
      step(1'b0, '0, 1'b1, 1'b0);
      burst(128, 1, 1'b0, 0);
      drain();

      // Convolution burst
      for (int i = 0; i < 4; i++) step(1'b1, conv[i], 1'b1, 1'b0);
      drain();

      // Single-cycle burst
      step(1'b1, 13'h0123, 1'b1, 1'b0);
      drain();

      // Backpressure: full burst with consumer stalled, then release
      burst(128, 0, 1'b1, 0);
      idle(5, 0);
      drain();

      // Overflow: two stalled bursts with a one-cycle gap, then clear
      burst(128, 0, 1'b1, 0);
      idle(1, 0);
      burst(128, 0, 1'b1, 0);
      idle(3, 0);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(2, 0);
      drain();

      // Full with simultaneous pop
      burst(128, 0, 1'b0, 256);
      idle(3, 0);
      step(1'b1, 13'h0055, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      drain();

      // Overflow raised in the same cycle a clear is requested
      burst(128, 0, 1'b1, 0);
      idle(2, 0);
      step(1'b1, 13'h0777, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(2, 0);
      step(1'b0, '0, 1'b0, 1'b1);
      drain();

      // Randomised bursts with random consumer readiness
      for (int b = 0; b < 24; b++) begin
         burst($urandom_range(1, 40), 2, 1'b1, 0);
         idle($urandom_range(1, 3), 2);
      end
      drain();

      // Reset mid-burst
      burst(50, 1, 1'b1, 0);
      i_rst_n     = 1'b0;
      i_out_valid = 1'b0;
      #1;
      chk("rst_pk_valid", {15'b0, o_pk_valid}, 16'h0000);
      chk("rst_pk_data", o_pk_data, 16'h0000);
      chk("rst_burst_len", {8'b0, o_burst_len}, 16'h0000);
      chk("rst_burst_done", {15'b0, o_burst_done}, 16'h0000);
      chk("rst_overflow", {15'b0, o_overflow}, 16'h0000);
      model_clear();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, conv[i], 1'b1, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/result_packer.md
Name: result_packer

Overview:
- Sits directly downstream of the image display/convolution core.
- Captures the core's unflow-controlled output bursts (o_out_valid/o_out_data): 4×4 display up to 128 pixels; convolution 4 results.
- Buffers them in a FIFO and re-emits them as 16-bit words on a valid/ready interface, tagging the last word of each burst.
- Reports burst length and flags overflow, so a stalled consumer never silently corrupts a frame.

Parameters:
- DEPTH, 128, FIFO entries; must cover the largest core burst (32 channels × 4 pixels).
- AW, 7, address width, log2(DEPTH).
- DW, 13, core output data width.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_out_valid  input  1  core output valid; contiguous high for the length of one burst.
- i_out_data  input  13  core output data.
- o_pk_valid  output  1  packed word available.
- o_pk_data  output  16  {last, 2'b00, data[12:0]}.
- i_pk_ready  input  1  consumer accepts word when high with o_pk_valid.
- o_burst_len  output  8  length of most recently completed burst.
- o_burst_done  output  1  one-cycle pulse when a burst's last sample is written.
- o_overflow  output  1  sticky; a sample was dropped because the FIFO was full.
- i_clr_ovf  input  1  synchronous clear of o_overflow.

Behaviour:
- **Reset** (async, active-low): all pointers, count, stage register, FSM, o_burst_len, o_burst_done, o_overflow go to 0; o_pk_valid=0, o_pk_data=0. Reset mid-burst discards all buffered and in-flight data; the next burst starts clean.
- **Stage register**: every cycle s_valid<=i_out_valid, s_data<=i_out_data.
- **Last detection**: when s_valid=1, the sample is written with last = ~i_out_valid, i.e. the next core sample is absent. A single-cycle burst therefore gets last=1.
- **Write**: allowed when count<DEPTH, or count==DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped and o_overflow<=1. A dropped sample that carries last=1 still ends the burst (FSM and o_burst_done behave as normal).
- **Read**: o_pk_valid = (count!=0). o_pk_data = mem[rd_ptr], read combinationally from the register array. Pop = o_pk_valid & i_pk_ready. o_pk_data is held stable while o_pk_valid=1 and i_pk_ready=0.
- **Count**: +1 on write only, −1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- **Latency**: a sample presented in cycle n with the FIFO empty appears on o_pk_valid in cycle n+2.
- **FSM**:
  - IDLE: s_valid=1 → BURST; bcnt<=1.
  - BURST: each s_valid sample increments bcnt, saturating at 255. When the sample has last=1 → IDLE, o_burst_len<=bcnt (including this sample), o_burst_done=1 for one cycle.
  - If last=1 on the first sample, IDLE → IDLE with o_burst_len=1 and o_burst_done pulsed.
  - Dropped samples are still counted in bcnt.
- **o_burst_len**: holds its value until the next burst completes.
- **i_clr_ovf vs new overflow**: if both occur in the same cycle, the new overflow wins (o_overflow=1).
- **Padding bits**: [14:13] are always 0.

Decomposition:
- Shared package: word-layout constants (LAST_BIT=15, DATA_LSB=0, DATA_W=13), DEPTH/AW defaults, FSM state encoding (IDLE, BURST).
- One natural sub-module: `sync_fifo_rf` (parameterised register-file FIFO with combinational read, count, full/empty).
- The stage register, last tagging, burst FSM and overflow logic stay in `result_packer`.

Test Plan:
- **Display burst**: 128 consecutive samples 0..127, i_pk_ready=1.
  - 128 words out, first in cycle n+2.
  - Word 127 = 16'h807F (last=1); all others last=0.
  - o_burst_len=128, o_burst_done pulse once, o_overflow=0.
- **Convolution burst**: 4 samples 13'h1FFF, 13'h0000, 13'h0ABC, 13'h0001.
  - Words 16'h1FFF, 16'h0000, 16'h0ABC, 16'h8001.
  - o_burst_len=4.
- **Backpressure**: i_pk_ready=0 during a 128-sample burst.
  - count reaches 128, o_overflow stays 0.
  - Release ready: 128 words drain in order, data held stable while stalled.
- **Overflow**: i_pk_ready=0, two 128-sample bursts back-to-back with a 1-cycle gap.
  - Second burst fully dropped; o_overflow=1; second o_burst_done pulse with o_burst_len=128.
  - i_clr_ovf → o_overflow=0.
- **Full with simultaneous pop**: FIFO full, i_pk_ready=1, new sample 13'h0055 arrives.
  - Write accepted, count stays 128, no overflow.
- **Reset mid-burst**: assert i_rst_n=0 after 50 of 128 samples.
  - o_pk_valid=0, o_burst_len=0 immediately.
  - Subsequent 4-sample burst yields exactly 4 words, o_burst_len=4.
